// File: rtl/pipeline_dmem_ctrl.sv
// Memory-stage data-bus controller: runs one req/ack transaction per M-stage access,
// stalls the pipeline until it completes, aligns lanes and aborts on misalignment or timeout.
module pipeline_dmem_ctrl #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_ctrl_mem_rd_enM,
    input  logic            i_ctrl_mem_wr_enM,
    input  logic [3:0]      i_ctrl_mem_byte_selM,
    input  logic [XLEN-1:0] i_alu_resultM,
    input  logic [XLEN-1:0] i_mem_writedataM,
    output logic            o_stall,
    output logic            o_dbus_req,
    output logic            o_dbus_we,
    output logic [XLEN-1:0] o_dbus_addr,
    output logic [3:0]      o_dbus_be,
    output logic [XLEN-1:0] o_dbus_wdata,
    input  logic            i_dbus_ack,
    input  logic [XLEN-1:0] i_dbus_rdata,
    output logic [XLEN-1:0] o_rdataM,
    output logic            o_rdata_validM,
    output logic            o_misaligned,
    output logic            o_bus_err
);

    // state  | meaning
    // IDLE   | waiting for an M-stage access
    // REQ    | request on the bus, waiting for ack or timeout
    // DONE   | result presented for one cycle, pipeline advances
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t            r_state, w_state_nxt;
    logic [CW-1:0]     r_cnt, w_cnt_nxt;
    logic              r_req, w_req_nxt;
    logic              r_we, w_we_nxt;
    logic [XLEN-1:0]   r_addr, w_addr_nxt;
    logic [3:0]        r_be, w_be_nxt;
    logic [XLEN-1:0]   r_wdata, w_wdata_nxt;
    logic [1:0]        r_off, w_off_nxt;
    logic              r_load, w_load_nxt;
    logic [XLEN-1:0]   r_rdata, w_rdata_nxt;
    logic              r_valid, w_valid_nxt;
    logic              r_mis, w_mis_nxt;
    logic              r_err, w_err_nxt;

    logic              w_access;
    logic              w_is_load;
    logic [1:0]        w_off;
    logic [7:0]        w_be_wide;
    logic              w_misaligned;
    logic [XLEN-1:0]   w_wdata_sh;
    logic [XLEN-1:0]   w_rdata_sh;

    assign w_access     = i_ctrl_mem_rd_enM | i_ctrl_mem_wr_enM;
    assign w_is_load    = i_ctrl_mem_rd_enM & ~i_ctrl_mem_wr_enM;
    assign w_off        = i_alu_resultM[1:0];
    // any mask bit pushed past lane 3 means the access straddles a word
    assign w_be_wide    = {4'b0000, i_ctrl_mem_byte_selM} << w_off;
    assign w_misaligned = |w_be_wide[7:4];
    assign w_wdata_sh   = i_mem_writedataM << {w_off, 3'b000};
    assign w_rdata_sh   = i_dbus_rdata >> {r_off, 3'b000};

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_req_nxt   = r_req;
        w_we_nxt    = r_we;
        w_addr_nxt  = r_addr;
        w_be_nxt    = r_be;
        w_wdata_nxt = r_wdata;
        w_off_nxt   = r_off;
        w_load_nxt  = r_load;
        w_rdata_nxt = r_rdata;
        w_valid_nxt = 1'b0;
        w_mis_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_access) begin
                    if (w_misaligned) begin
                        w_state_nxt = S_DONE;
                        w_mis_nxt   = 1'b1;
                        w_rdata_nxt = '0;
                        w_valid_nxt = w_is_load;
                    end else begin
                        w_state_nxt = S_REQ;
                        w_addr_nxt  = {i_alu_resultM[XLEN-1:2], 2'b00};
                        w_be_nxt    = w_be_wide[3:0];
                        w_we_nxt    = i_ctrl_mem_wr_enM;
                        w_wdata_nxt = w_wdata_sh;
                        w_off_nxt   = w_off;
                        w_load_nxt  = w_is_load;
                        w_req_nxt   = 1'b1;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            S_REQ: begin
                if (i_dbus_ack) begin
                    w_state_nxt = S_DONE;
                    w_req_nxt   = 1'b0;
                    w_rdata_nxt = r_load ? w_rdata_sh : '0;
                    w_valid_nxt = r_load;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    w_state_nxt = S_DONE;
                    w_req_nxt   = 1'b0;
                    w_rdata_nxt = '0;
                    w_err_nxt   = 1'b1;
                    w_valid_nxt = r_load;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_req_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_be    <= '0;
            r_wdata <= '0;
            r_off   <= '0;
            r_load  <= 1'b0;
            r_rdata <= '0;
            r_valid <= 1'b0;
            r_mis   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_req   <= w_req_nxt;
            r_we    <= w_we_nxt;
            r_addr  <= w_addr_nxt;
            r_be    <= w_be_nxt;
            r_wdata <= w_wdata_nxt;
            r_off   <= w_off_nxt;
            r_load  <= w_load_nxt;
            r_rdata <= w_rdata_nxt;
            r_valid <= w_valid_nxt;
            r_mis   <= w_mis_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // gated by reset so the freeze releases the moment reset asserts
    assign o_stall        = i_rstn & w_access & (r_state != S_DONE);
    assign o_dbus_req     = r_req;
    assign o_dbus_we      = r_we;
    assign o_dbus_addr    = r_addr;
    assign o_dbus_be      = r_be;
    assign o_dbus_wdata   = r_wdata;
    assign o_rdataM       = r_rdata;
    assign o_rdata_validM = r_valid;
    assign o_misaligned   = r_mis;
    assign o_bus_err      = r_err;

endmodule

// File: tb/tb_pipeline_dmem_ctrl.sv
// Directed bench for pipeline_dmem_ctrl: hand-computed expectations for stores, loads,
// misalignment, timeout, back-to-back accesses and mid-transaction reset.
module tb_pipeline_dmem_ctrl;

    logic        i_clk;
    logic        i_rstn;
    logic        i_ctrl_mem_rd_enM;
    logic        i_ctrl_mem_wr_enM;
    logic [3:0]  i_ctrl_mem_byte_selM;
    logic [31:0] i_alu_resultM;
    logic [31:0] i_mem_writedataM;
    logic        o_stall;
    logic        o_dbus_req;
    logic        o_dbus_we;
    logic [31:0] o_dbus_addr;
    logic [3:0]  o_dbus_be;
    logic [31:0] o_dbus_wdata;
    logic        i_dbus_ack;
    logic [31:0] i_dbus_rdata;
    logic [31:0] o_rdataM;
    logic        o_rdata_validM;
    logic        o_misaligned;
    logic        o_bus_err;

    pipeline_dmem_ctrl #(.XLEN(32), .TIMEOUT(16)) dut (
        .i_clk               (i_clk),
        .i_rstn              (i_rstn),
        .i_ctrl_mem_rd_enM   (i_ctrl_mem_rd_enM),
        .i_ctrl_mem_wr_enM   (i_ctrl_mem_wr_enM),
        .i_ctrl_mem_byte_selM(i_ctrl_mem_byte_selM),
        .i_alu_resultM       (i_alu_resultM),
        .i_mem_writedataM    (i_mem_writedataM),
        .o_stall             (o_stall),
        .o_dbus_req          (o_dbus_req),
        .o_dbus_we           (o_dbus_we),
        .o_dbus_addr         (o_dbus_addr),
        .o_dbus_be           (o_dbus_be),
        .o_dbus_wdata        (o_dbus_wdata),
        .i_dbus_ack          (i_dbus_ack),
        .i_dbus_rdata        (i_dbus_rdata),
        .o_rdataM            (o_rdataM),
        .o_rdata_validM      (o_rdata_validM),
        .o_misaligned        (o_misaligned),
        .o_bus_err           (o_bus_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // results captured by do_access
    int          s_stall, s_req;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_be;
    logic        s_we, s_valid, s_mis, s_err, s_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [3:0] sel,
                         input logic [31:0] addr, input logic [31:0] wd);
        i_ctrl_mem_rd_enM    = rd;
        i_ctrl_mem_wr_enM    = wr;
        i_ctrl_mem_byte_selM = sel;
        i_alu_resultM        = addr;
        i_mem_writedataM     = wd;
    endtask

    // Holds the access until the stall drops (DONE), acking on REQ cycle ack_at (0 = never).
    // Entered and left 1ns after a rising edge.
    task automatic do_access(input logic rd, input logic wr, input logic [3:0] sel,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input int ack_at, input logic [31:0] rdata);
        drive(rd, wr, sel, addr, wd);
        s_stall = 0; s_req = 0; s_done = 1'b0;
        for (int c = 0; c < 40 && !s_done; c++) begin
            #1;
            i_dbus_ack   = 1'b0;
            i_dbus_rdata = 32'h0;
            if (o_stall) s_stall++;
            if (o_dbus_req) begin
                s_req++;
                s_addr  = o_dbus_addr;
                s_be    = o_dbus_be;
                s_we    = o_dbus_we;
                s_wdata = o_dbus_wdata;
                if (s_req == ack_at) begin
                    i_dbus_ack   = 1'b1;
                    i_dbus_rdata = rdata;
                end
            end
            if (!o_stall) begin
                s_rdata = o_rdataM;
                s_valid = o_rdata_validM;
                s_mis   = o_misaligned;
                s_err   = o_bus_err;
                s_done  = 1'b1;
            end
            @(posedge i_clk);
            #1;
            i_dbus_ack = 1'b0;
        end
        chk("access_completes", {31'h0, s_done}, 32'h1);
    endtask

    int stall_total;

    initial begin
        i_rstn = 1'b0;
        i_dbus_ack = 1'b0;
        i_dbus_rdata = 32'h0;
        drive(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        s_addr = 0; s_wdata = 0; s_rdata = 0; s_be = 0; s_we = 0;
        s_valid = 0; s_mis = 0; s_err = 0;
        #12;
        chk("rst_req",   {31'h0, o_dbus_req}, 32'h0);
        chk("rst_stall", {31'h0, o_stall}, 32'h0);
        chk("rst_outs",  {28'h0, o_rdata_validM, o_misaligned, o_bus_err, o_dbus_we}, 32'h0);
        chk("rst_rdata", o_rdataM, 32'h0);
        @(posedge i_clk); #1;
        i_rstn = 1'b1;

        // no access: no stall, no bus activity
        @(posedge i_clk); #1;
        chk("noacc_stall", {31'h0, o_stall}, 32'h0);
        @(posedge i_clk); #1;
        chk("noacc_req", {31'h0, o_dbus_req}, 32'h0);

        // store word, ack on third REQ cycle
        do_access(1'b0, 1'b1, 4'b1111, 32'h100, 32'hDEADBEEF, 3, 32'h0);
        chk("sw_addr",  s_addr, 32'h100);
        chk("sw_be",    {28'h0, s_be}, 32'hF);
        chk("sw_we",    {31'h0, s_we}, 32'h1);
        chk("sw_wdata", s_wdata, 32'hDEADBEEF);
        chk("sw_stall", s_stall, 4);
        chk("sw_valid", {31'h0, s_valid}, 32'h0);
        drive(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        @(posedge i_clk); #1;

        // load byte at offset 3, immediate ack
        do_access(1'b1, 1'b0, 4'b0001, 32'h203, 32'h0, 1, 32'hAABBCCDD);
        chk("lb_addr",  s_addr, 32'h200);
        chk("lb_be",    {28'h0, s_be}, 32'h8);
        chk("lb_we",    {31'h0, s_we}, 32'h0);
        chk("lb_stall", s_stall, 2);
        chk("lb_rdata", s_rdata, 32'h000000AA);
        chk("lb_valid", {31'h0, s_valid}, 32'h1);
        drive(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        @(posedge i_clk); #1;

        // misaligned load word at 0x06
        do_access(1'b1, 1'b0, 4'b1111, 32'h06, 32'h0, 1, 32'h12345678);
        chk("mis_req",   s_req, 0);
        chk("mis_pulse", {31'h0, s_mis}, 32'h1);
        chk("mis_stall", s_stall, 1);
        chk("mis_rdata", s_rdata, 32'h0);
        chk("mis_valid", {31'h0, s_valid}, 32'h1);
        drive(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        @(posedge i_clk); #1;
        chk("mis_pulse_end", {31'h0, o_misaligned}, 32'h0);

        // store half at 0x12
        do_access(1'b0, 1'b1, 4'b0011, 32'h12, 32'h00001234, 1, 32'h0);
        chk("sh_addr",  s_addr, 32'h10);
        chk("sh_be",    {28'h0, s_be}, 32'hC);
        chk("sh_wdata", s_wdata, 32'h12340000);
        drive(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        @(posedge i_clk); #1;

        // load half at offset 2, ack on second REQ cycle
        do_access(1'b1, 1'b0, 4'b0011, 32'h32, 32'h0, 2, 32'h11223344);
        chk("lh_be",    {28'h0, s_be}, 32'hC);
        chk("lh_stall", s_stall, 3);
        chk("lh_rdata", s_rdata, 32'h00001122);
        chk("lh_flags", {30'h0, s_mis, s_err}, 32'h0);
        drive(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        @(posedge i_clk); #1;

        // load with no ack: timeout
        do_access(1'b1, 1'b0, 4'b1111, 32'h40, 32'h0, 0, 32'h0);
        chk("to_req",   s_req, 16);
        chk("to_stall", s_stall, 17);
        chk("to_err",   {31'h0, s_err}, 32'h1);
        chk("to_rdata", s_rdata, 32'h0);
        chk("to_valid", {31'h0, s_valid}, 32'h1);
        drive(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        i_dbus_ack = 1'b1;
        i_dbus_rdata = 32'hFFFFFFFF;
        @(posedge i_clk); #1;
        i_dbus_ack = 1'b0;
        chk("late_ack_req",   {31'h0, o_dbus_req}, 32'h0);
        chk("late_ack_valid", {31'h0, o_rdata_validM}, 32'h0);
        @(posedge i_clk); #1;
        chk("late_ack_rdata", o_rdataM, 32'h0);
        chk("late_ack_err",   {31'h0, o_bus_err}, 32'h0);

        // back-to-back load then store, immediate acks
        do_access(1'b1, 1'b0, 4'b1111, 32'h80, 32'h0, 1, 32'hCAFEF00D);
        stall_total = s_stall;
        chk("b2b_ld_req",   s_req, 1);
        chk("b2b_ld_rdata", s_rdata, 32'hCAFEF00D);
        do_access(1'b0, 1'b1, 4'b0001, 32'h85, 32'h000000A5, 1, 32'h0);
        stall_total += s_stall;
        chk("b2b_st_req",   s_req, 1);
        chk("b2b_st_addr",  s_addr, 32'h84);
        chk("b2b_st_wdata", s_wdata, 32'h0000A500);
        chk("b2b_st_we",    {31'h0, s_we}, 32'h1);
        chk("b2b_stall",    stall_total, 4);
        drive(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        @(posedge i_clk); #1;

        // reset during REQ
        drive(1'b1, 1'b0, 4'b1111, 32'h300, 32'h0);
        @(posedge i_clk); #1;
        chk("rstm_req_before", {31'h0, o_dbus_req}, 32'h1);
        #2;
        i_rstn = 1'b0;
        i_dbus_ack = 1'b1;
        i_dbus_rdata = 32'h55555555;
        #1;
        chk("rstm_req_async",   {31'h0, o_dbus_req}, 32'h0);
        chk("rstm_stall_async", {31'h0, o_stall}, 32'h0);
        @(posedge i_clk); #1;
        i_rstn = 1'b1;
        drive(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        @(posedge i_clk); #1;
        i_dbus_ack = 1'b0;
        chk("rstm_idle_req",   {31'h0, o_dbus_req}, 32'h0);
        chk("rstm_idle_valid", {31'h0, o_rdata_validM}, 32'h0);
        chk("rstm_idle_rdata", o_rdataM, 32'h0);
        do_access(1'b1, 1'b0, 4'b1111, 32'h304, 32'h0, 1, 32'h0BADC0DE);
        chk("rstm_new_addr",  s_addr, 32'h304);
        chk("rstm_new_stall", s_stall, 2);
        chk("rstm_new_rdata", s_rdata, 32'h0BADC0DE);
        drive(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        @(posedge i_clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_dmem_ctrl.md
Name: pipeline_dmem_ctrl

Overview:
Memory-stage data-bus controller for the RV32I 5-stage pipeline. Takes the EX/MEM register outputs (access enables, byte mask, address, store data) and runs a req/ack transaction on a variable-latency data bus. Holds o_stall high until the access completes so the F/D/E/M registers freeze. Also handles lane alignment, misalignment detection and a bus timeout.

Parameters:
XLEN, 32, data/address width
TIMEOUT, 16, maximum REQ-state cycles without ack before abort (≥2)

Ports:
i_clk  in  1  clock
i_rstn  in  1  reset, asynchronous, active-low
i_ctrl_mem_rd_enM  in  1  load in M stage
i_ctrl_mem_wr_enM  in  1  store in M stage
i_ctrl_mem_byte_selM  in  4  unshifted mask: 0001 byte, 0011 half, 1111 word
i_alu_resultM  in  XLEN  byte address
i_mem_writedataM  in  XLEN  store data, LSB-justified
o_stall  out  1  freeze pipeline registers (combinational)
o_dbus_req  out  1  bus request (registered)
o_dbus_we  out  1  1 = write
o_dbus_addr  out  XLEN  word-aligned address
o_dbus_be  out  4  lane byte enables
o_dbus_wdata  out  XLEN  lane-aligned store data
i_dbus_ack  in  1  transaction complete, valid one cycle
i_dbus_rdata  in  XLEN  read word, valid with ack
o_rdataM  out  XLEN  load data, right-justified, not extended
o_rdata_validM  out  1  o_rdataM valid this cycle
o_misaligned  out  1  one-cycle pulse, access rejected
o_bus_err  out  1  one-cycle pulse, timeout abort

Behaviour:
- Reset: state IDLE, timeout counter 0, all outputs 0. Reset mid-transaction drops o_dbus_req immediately; a pending ack after reset is ignored.
- access = rd_en | wr_en. If both are asserted, the write takes precedence.
- off = addr[1:0]; be = byte_sel << off (4-bit result).
- Misaligned if any mask bit shifts out: half at off=3, or word at off≠0.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - If access and aligned: load o_dbus_addr={addr[XLEN-1:2],2'b00}, o_dbus_be=be, o_dbus_we=wr_en, o_dbus_wdata=wdata<<(8*off), set o_dbus_req=1, clear counter, go to REQ.
  - If access and misaligned: no request, o_misaligned pulse (asserted in DONE), go to DONE with o_rdataM=0.
- REQ:
  - Request outputs are held stable.
  - Ack sampled high: drop req. For a load, latch o_rdataM = i_dbus_rdata >> (8*off); for a store, o_rdataM=0. Go to DONE.
  - No ack and counter==TIMEOUT-1: drop req, o_rdataM=0, o_bus_err pulse in DONE, go to DONE.
  - Otherwise: counter+1.
- DONE:
  - o_rdata_validM=1 for loads, including error cases; 0 for stores.
  - Unconditionally go to IDLE, so the same M-stage instruction is never reissued.
- o_stall = access & (state != DONE). It is high in IDLE with access, and throughout REQ. In DONE it is 0, so the pipeline advances at the end of DONE.
- Latency: ack in the first REQ cycle gives 2 stall cycles. Each extra ack-wait cycle adds 1. Timeout gives TIMEOUT+1 stall cycles.
- Back-to-back accesses: the next instruction is seen in IDLE the cycle after DONE. No bubble is inserted by the controller beyond this.
- An ack outside REQ is ignored.
- A non-access instruction in M causes no stall and no bus activity.

Test Plan:
- Store word at addr 0x100, data 0xDEADBEEF, ack after 3 REQ cycles → addr=0x100, be=1111, wdata=0xDEADBEEF, we=1. o_stall high 4 cycles. o_rdata_validM stays 0.
- Load byte at addr 0x203, rdata=0xAABBCCDD, ack in first REQ cycle → addr=0x200, be=1000. o_stall high 2 cycles. DONE shows o_rdataM=0x000000AA, valid=1.
- Store half at addr 0x12, data 0x00001234 → be=1100, wdata=0x12340000. Load word at 0x06 → no req, o_misaligned pulse, o_stall high 1 cycle, o_rdataM=0.
- Load with no ack, TIMEOUT=16 → req high 16 cycles then dropped, o_bus_err pulse, o_rdataM=0, o_stall high 17 cycles. A late ack afterwards is ignored.
- Back-to-back load/store pair with immediate acks → two separate transactions, no reissue of the first. Total stall 4 cycles.
- Assert i_rstn low during REQ → o_dbus_req and o_stall drop asynchronously. After release, state is IDLE and a new access starts cleanly.
